fb_fetch_arbiter: RTL and testbench

FB_FETCH_ARBITER -- requirements
Module: fb_fetch_arbiter

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_linebuf.sv | 32 +++
 rtl/fb_fetch_arbiter.sv | 138 +++++++++++++
 tb/tb_fb_fetch_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the framebuffer fetch arbiter.
// Default raster timing is 640x480@60 with a 320-pixel, 8 bpp source row.
package fb_pkg;

    localparam int unsigned FB_H_VISIBLE      = 640;
    localparam int unsigned FB_H_TOTAL        = 800;
    localparam int unsigned FB_V_VISIBLE      = 480;
    localparam int unsigned FB_V_TOTAL        = 525;
    localparam int unsigned FB_WORDS_PER_LINE = 80;

    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PIX_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_state_e;

    // Byte 0 sits in bits [7:0] of a framebuffer word.
    function automatic logic [PIX_W-1:0] word_byte(input logic [DATA_W-1:0] w,
                                                   input logic [1:0]        sel);
        return PIX_W'(w >> {sel, 3'b000});
    endfunction

endpackage

// File: rtl/fb_linebuf.sv
// One-line buffer for the fetch arbiter: synchronous write port, combinational read port.
// Contents are deliberately not reset; out-of-range reads return zero.
module fb_linebuf
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = FB_WORDS_PER_LINE,
    parameter int unsigned AW    = 7
) (
    input  logic              clk_pix,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_pix) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (32'(raddr) < DEPTH) begin
            rdata_c = mem[raddr];
        end
    end

endmodule

// File: rtl/fb_fetch_arbiter.sv
// Framebuffer fetch arbiter: prefetches the next source row into a line buffer during
// horizontal blanking, shares the single-port RAM with a host write channel (fetch wins),
// and emits line-doubled 8 bpp pixel indices. Define FB_ARB_UNDERRUN_EN for late-fetch detection.
module fb_fetch_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned H_VISIBLE      = FB_H_VISIBLE,
    parameter int unsigned H_TOTAL        = FB_H_TOTAL,
    parameter int unsigned V_VISIBLE      = FB_V_VISIBLE,
    parameter int unsigned V_TOTAL        = FB_V_TOTAL,
    parameter int unsigned WORDS_PER_LINE = FB_WORDS_PER_LINE
) (
    input  logic                 clk_pix,
    input  logic                 resetn,
    input  logic [CNT_W-1:0]     hcount,
    input  logic [CNT_W-1:0]     vcount,
    input  logic                 de,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [PIX_W-1:0]     pix_data,
    output logic                 underrun
);

    localparam int unsigned IDX_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned COL_W = CNT_W - 3;
    localparam int unsigned LB_AW = (IDX_W > COL_W) ? IDX_W : COL_W;

    fb_state_e              state;
    logic [IDX_W-1:0]       word_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   rd_pend;
    logic [CNT_W-1:0]       vnext;
    logic                   fetch_trig;
    logic [FB_ADDR_W-1:0]   fetch_addr;
    logic [DATA_W-1:0]      lb_rdata;

    // Next displayed line selects the source row; vnext>>1 gives line doubling.
    always_comb begin
        vnext      = (vcount == CNT_W'(V_TOTAL - 1)) ? '0 : vcount + CNT_W'(1);
        fetch_trig = (hcount == CNT_W'(H_VISIBLE)) && (vnext < CNT_W'(V_VISIBLE));
        fetch_addr = FB_ADDR_W'(32'(vnext >> 1) * WORDS_PER_LINE + 32'(word_idx));
    end

    // Fetch sequencer; rd_pend/rd_idx track the read whose data returns next cycle.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            word_idx <= '0;
            rd_idx   <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= (state == FETCH);
            rd_idx  <= word_idx;
            case (state)
                IDLE: begin
                    if (fetch_trig) begin
                        state    <= FETCH;
                        word_idx <= '0;
                    end
                end
                FETCH: begin
                    if (word_idx == IDX_W'(WORDS_PER_LINE - 1)) begin
                        state    <= DRAIN;
                        word_idx <= '0;
                    end else begin
                        word_idx <= word_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port mux: the host only gets the port in IDLE cycles that do not start a fetch.
    always_comb begin
        wr_ready  = resetn && (state == IDLE) && !fetch_trig;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (state == FETCH) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end else if (wr_valid && wr_ready) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
        end
    end

    fb_linebuf #(
        .DEPTH (WORDS_PER_LINE),
        .AW    (LB_AW)
    ) u_linebuf (
        .clk_pix (clk_pix),
        .we      (rd_pend),
        .waddr   (LB_AW'(rd_idx)),
        .wdata   (mem_rdata),
        .raddr   (LB_AW'(hcount >> 3)),
        .rdata_c (lb_rdata)
    );

    // Each word covers 8 output pixels: 4 source bytes, each shown twice.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            pix_data <= '0;
        end else if (de && (hcount < CNT_W'(H_TOTAL))) begin
            pix_data <= word_byte(lb_rdata, hcount[2:1]);
        end else begin
            pix_data <= '0;
        end
    end

`ifdef FB_ARB_UNDERRUN_EN
    // Sticky: a fetch still running on the last pixel of a line arrived too late.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            underrun <= 1'b0;
        end else if ((hcount == CNT_W'(H_TOTAL - 1)) && (state != IDLE)) begin
            underrun <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Self-checking bench for fb_fetch_arbiter: raster-line stimulus, RAM model, and a
// line-level reference model of fetch windows, host arbitration and pixel output.
module tb_fb_fetch_arbiter;

    localparam int HV  = 640;
    localparam int HT  = 800;
    localparam int VV  = 480;
    localparam int VT  = 525;
    localparam int WPL = 80;

    logic        clk_pix = 1'b0;
    logic        resetn;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        de;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [31:0] wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  pix_data;
    logic        underrun;

    fb_fetch_arbiter dut (
        .clk_pix   (clk_pix),
        .resetn    (resetn),
        .hcount    (hcount),
        .vcount    (vcount),
        .de        (de),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .underrun  (underrun)
    );

    always #5 clk_pix = ~clk_pix;

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Single-port synchronous RAM, read latency 1, preloaded with init_val().
    bit [31:0] ram    [32768];
    bit        ram_wr [32768];
    int        n_wr_123 = 0;
    always @(posedge clk_pix) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
                if (mem_addr == 15'h0123) n_wr_123 <= n_wr_123 + 1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    typedef struct packed {
        logic [14:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] shadow [int];
    logic [31:0] exp_lb [WPL];
    bit          lb_known;
    int          prev_h;
    bit          prev_de;
    int          wr_gate;
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  dbl_tbl [8] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

    function automatic logic [31:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    function automatic logic [7:0] exp_pix_of(input int h);
        logic [31:0] w;
        int          sel;
        w   = exp_lb[h / 8];
        sel = (h / 2) % 4;
        return w[8*sel +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({tag, "_mem_en"},   32'(mem_en),   32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_pix"},      32'(pix_data), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    // One pixel clock: drive after the edge, let combinational outputs settle.
    task automatic drive(input int h, input int v, input bit d);
        @(posedge clk_pix);
        #1;
        hcount = 10'(h);
        vcount = 10'(v);
        de     = d;
        if (wq.size() > 0 && h >= wr_gate) begin
            wr_valid = 1'b1;
            wr_addr  = wq[0].a;
            wr_data  = wq[0].d;
        end else begin
            wr_valid = 1'b0;
        end
        #1;
    endtask

    task automatic queue_random(input int row_hit, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t w;
            if (row_hit >= 0 && $urandom_range(0, 1) == 1)
                w.a = 15'(row_hit * WPL + int'($urandom_range(0, WPL - 1)));
            else
                w.a = 15'($urandom_range(160, 19199));
            w.d = $urandom;
            wq.push_back(w);
        end
    endtask

    // Reference: a fetch line blocks the host for hcount HV..HV+WPL+1 and reads
    // row (vnext/2) word k at hcount HV+1+k; the buffer holds that row afterwards.
    task automatic run_line(input int v, input int h0, input int h1, input bit allow);
        int vn;
        int row;
        bit fetch;
        bit d;
        bit busy;
        bit rd;
        vn    = (v == VT - 1) ? 0 : v + 1;
        row   = vn / 2;
        fetch = allow && (vn < VV);
        for (int h = h0; h <= h1; h++) begin
            d    = (h < HV) && (v < VV);
            busy = fetch && (h >= HV) && (h <= HV + WPL + 1);
            rd   = fetch && (h >= HV + 1) && (h <= HV + WPL);
            drive(h, v, d);
            check("wr_ready", 32'(wr_ready), 32'(!busy));
            if (rd) begin
                check("rd_en",   32'(mem_en),   32'd1);
                check("rd_we",   32'(mem_we),   32'd0);
                check("rd_addr", 32'(mem_addr), 32'(row * WPL + h - HV - 1));
            end else if (wr_valid && !busy) begin
                check("wr_en",    32'(mem_en),    32'd1);
                check("wr_we",    32'(mem_we),    32'd1);
                check("wr_addr",  32'(mem_addr),  32'(wq[0].a));
                check("wr_wdata", mem_wdata,      wq[0].d);
                shadow[int'(wq[0].a)] = wq[0].d;
                void'(wq.pop_front());
            end else begin
                check("idle_en", 32'(mem_en), 32'd0);
            end
            if (!prev_de)
                check("pix_blank", 32'(pix_data), 32'd0);
            else if (lb_known)
                check("pix", 32'(pix_data), 32'(exp_pix_of(prev_h)));
            if (v == 3 && h >= 1 && h <= 8)
                check("pix_dbl", 32'(pix_data), 32'(dbl_tbl[h - 1]));
            check("underrun_idle", 32'(underrun), 32'd0);
            prev_h  = h;
            prev_de = d;
            if (fetch && h == HV + WPL + 1) begin
                for (int k = 0; k < WPL; k++) exp_lb[k] = shadow_rd(row * WPL + k);
                lb_known = 1'b1;
            end
        end
    endtask

    initial begin
        int v;
        logic [31:0] exp_ur;
`ifdef FB_ARB_UNDERRUN_EN
        exp_ur = 32'd1;
`else
        exp_ur = 32'd0;
`endif
        resetn   = 1'b0;
        hcount   = '0;
        vcount   = '0;
        de       = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        lb_known = 1'b0;
        prev_de  = 1'b0;
        prev_h   = 0;
        wr_gate  = 0;

        repeat (3) @(posedge clk_pix);
        #2;
        check_reset_outputs("por");
        resetn = 1'b1;

        // Host write held from 635 across the fetch window: 5 accepted before, 1 after.
        for (int i = 0; i < 6; i++) wq.push_back('{a: 15'h0123, d: 32'hDEADBEEF});
        wr_gate = 635;
        run_line(0, 0, HT - 1, 1'b1);
        wr_gate = 0;
        check("wr123_count", 32'(n_wr_123), 32'd6);
        check("wr123_queue", 32'(wq.size()), 32'd0);

        wq.push_back('{a: 15'd80, d: 32'h44332211});
        for (int l = 1; l <= 6; l++) run_line(l, 0, HT - 1, 1'b1);

        repeat (3) begin
            v = int'($urandom_range(7, 470));
            queue_random((v + 1) / 2, int'($urandom_range(1, 6)));
            run_line(v, 0, HT - 1, 1'b1);
            run_line(v + 1, 0, HT - 1, 1'b1);
        end

        run_line(478, 0, HT - 1, 1'b1);
        run_line(479, 0, HT - 1, 1'b1);
        run_line(523, 0, HT - 1, 1'b1);
        run_line(524, 0, HT - 1, 1'b1);
        run_line(0, 0, HT - 1, 1'b1);

        // Reset in the middle of a fetch, then a fresh complete fetch.
        run_line(10, 0, 700, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_fetch");
        lb_known = 1'b0;
        prev_de  = 1'b0;
        for (int h = 701; h <= 705; h++) begin
            drive(h, 10, 1'b0);
            check("rst_hold_ready", 32'(wr_ready), 32'd0);
            check("rst_hold_en",    32'(mem_en),   32'd0);
        end
        drive(706, 10, 1'b0);
        resetn = 1'b1;
        run_line(10, 707, HT - 1, 1'b0);
        run_line(12, 0, HT - 1, 1'b1);
        run_line(13, 0, HT - 1, 1'b1);

        // Fetch still running on the last pixel of a line.
        run_line(20, 0, 660, 1'b1);
        drive(HT - 1, 20, 1'b0);
        drive(0, 21, 1'b0);
        check("underrun_set", 32'(underrun), exp_ur);
        for (int h = 1; h <= 150; h++) drive(h, 21, 1'b0);
        check("underrun_sticky", 32'(underrun), exp_ur);
        check("ur_idle_ready",   32'(wr_ready), 32'd1);
        drive(HT - 1, 21, 1'b0);
        drive(0, 22, 1'b0);
        check("underrun_idle_end", 32'(underrun), exp_ur);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_ur");
        drive(1, 22, 1'b0);
        resetn   = 1'b1;
        lb_known = 1'b0;
        prev_de  = 1'b0;
        run_line(30, 0, HT - 1, 1'b1);
        run_line(31, 0, HT - 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
